// File: rtl/seg7_decode_monitor.sv
// Watches an active-low 7-segment bus and decodes stable digit patterns.
// It also flags illegal patterns and breaks in an expected counting sequence.
module seg7_decode_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int MOD           = 8
) (
    input  logic       CLOCK_50,
    input  logic [0:0] KEY,
    input  logic [0:6] HEX_IN,
    output logic [3:0] DIGIT,
    output logic       DIGIT_VALID,
    output logic       PAT_ERR,
    output logic       SEQ_ERR,
    output logic       LOCKED,
    output logic [7:0] CHG_CNT,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] CNT_QUAL = 4'(STABLE_CYCLES - 2);
    localparam logic [4:0] MOD_L    = 5'(MOD);
    localparam logic [0:6] BLANK    = 7'b1111111;

    logic       rst_n;
    logic [0:6] sync1;
    logic [0:6] s;
    logic [0:6] s_prev;
    logic [3:0] stab_cnt;
    state_t     state;
    state_t     state_nxt;
    logic       has_prior;
    logic       chg;
    logic       qualify;
    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_digit;
    logic       acc_new;
    logic       acc_blank;
    logic       acc_illegal;
    logic [4:0] inc_digit;
    logic [4:0] seq_next;
    logic       seq_bad;

    assign rst_n = KEY[0];

    // Two-flop synchronizer; s_prev lets us see every change of the sample.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= BLANK;
            s      <= BLANK;
            s_prev <= BLANK;
        end else begin
            sync1  <= HEX_IN;
            s      <= sync1;
            s_prev <= s;
        end
    end

    assign chg = (s != s_prev);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= 4'd0;
        end else if (chg) begin
            stab_cnt <= 4'd0;
        end else if (stab_cnt != CNT_MAX) begin
            stab_cnt <= stab_cnt + 4'd1;
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_digit = 4'd0;
        case (s)
            7'b0000001: dec_digit = 4'd0;
            7'b1001111: dec_digit = 4'd1;
            7'b0010010: dec_digit = 4'd2;
            7'b0000110: dec_digit = 4'd3;
            7'b1001100: dec_digit = 4'd4;
            7'b0100100: dec_digit = 4'd5;
            7'b0100000: dec_digit = 4'd6;
            7'b0001111: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0000100: dec_digit = 4'd9;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Qualification fires on the edge where the counter reaches its ceiling,
    // so the decision registers STABLE_CYCLES+2 edges after an input step.
    assign qualify = (state == ST_SETTLE) && !chg && (stab_cnt == CNT_QUAL);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (chg) begin
            state_nxt = ST_SETTLE;
        end else if (qualify) begin
            if (dec_blank || !dec_legal) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = ST_LOCKED;
            end
        end
    end

    always_comb begin
        LOCKED      = (state == ST_LOCKED);
        dbg_state   = state;
        acc_new     = qualify && dec_legal && !dec_blank && (!has_prior || (dec_digit != DIGIT));
        acc_blank   = qualify && dec_blank;
        acc_illegal = qualify && !dec_legal;
    end

    assign inc_digit = {1'b0, DIGIT} + 5'd1;
    assign seq_next  = inc_digit % MOD_L;
    // Digit 0 restarts the count; out-of-range digits are always an error.
    assign seq_bad   = ({1'b0, dec_digit} >= MOD_L) ||
                       (has_prior && (dec_digit != 4'd0) && ({1'b0, dec_digit} != seq_next));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            DIGIT       <= 4'd0;
            DIGIT_VALID <= 1'b0;
            PAT_ERR     <= 1'b0;
            SEQ_ERR     <= 1'b0;
            CHG_CNT     <= 8'd0;
            has_prior   <= 1'b0;
        end else begin
            DIGIT_VALID <= acc_new;
            PAT_ERR     <= acc_illegal;
            if (acc_new) begin
                DIGIT     <= dec_digit;
                CHG_CNT   <= CHG_CNT + 8'd1;
                has_prior <= 1'b1;
                if (seq_bad) begin
                    SEQ_ERR <= 1'b1;
                end
            end else if (acc_blank || acc_illegal) begin
                has_prior <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Directed bench for seg7_decode_monitor: a run-length model of the sampled
// input is compared every cycle, plus literal checks per scenario.
module tb_seg7_decode_monitor;

    localparam int STABLE = 4;
    localparam int MODV   = 8;
    localparam int CAP    = 255;

    logic       CLOCK_50;
    logic [0:0] KEY;
    logic [0:6] HEX_IN;
    logic [3:0] DIGIT;
    logic       DIGIT_VALID;
    logic       PAT_ERR;
    logic       SEQ_ERR;
    logic       LOCKED;
    logic [7:0] CHG_CNT;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int dv_count = 0;
    int pe_count = 0;
    int low_count = 0;

    logic [0:6] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};
    localparam logic [0:6] BLANK   = 7'b1111111;
    localparam logic [0:6] ILLEGAL = 7'b1111110;

    seg7_decode_monitor #(.STABLE_CYCLES(STABLE), .MOD(MODV)) dut (
        .CLOCK_50    (CLOCK_50),
        .KEY         (KEY),
        .HEX_IN      (HEX_IN),
        .DIGIT       (DIGIT),
        .DIGIT_VALID (DIGIT_VALID),
        .PAT_ERR     (PAT_ERR),
        .SEQ_ERR     (SEQ_ERR),
        .LOCKED      (LOCKED),
        .CHG_CNT     (CHG_CNT),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the sample stream is the input delayed two edges; a pattern is
    // qualified when its run of identical samples reaches STABLE.
    logic [0:6] m_s1, m_s2, m_last, m_cur;
    int         m_run;
    int         m_digit, m_cnt;
    bit         m_valid, m_pat, m_seq, m_locked, m_prior;

    function automatic int decode(input logic [0:6] p);
        for (int i = 0; i < 10; i++) begin
            if (seg_tab[i] == p) return i;
        end
        if (p == BLANK) return -1;
        return -2;
    endfunction

    always @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            m_s1 = BLANK; m_s2 = BLANK; m_last = BLANK; m_run = CAP;
            m_digit = 0; m_cnt = 0; m_valid = 0; m_pat = 0; m_seq = 0;
            m_locked = 0; m_prior = 0;
        end else begin
            int d;
            m_cur = m_s2;
            m_s2  = m_s1;
            m_s1  = HEX_IN;
            m_valid = 0;
            m_pat   = 0;
            if (m_cur == m_last) begin
                if (m_run < CAP) m_run++;
            end else begin
                m_run    = 1;
                m_last   = m_cur;
                m_locked = 0;
            end
            if (m_run == STABLE) begin
                d = decode(m_cur);
                if (d >= 0) begin
                    if (!m_prior || d != m_digit) begin
                        if (d >= MODV) m_seq = 1;
                        else if (m_prior && d != 0 && d != (m_digit + 1) % MODV) m_seq = 1;
                        m_valid = 1;
                        m_digit = d;
                        m_cnt   = (m_cnt + 1) % 256;
                        m_prior = 1;
                    end
                    m_locked = 1;
                end else begin
                    if (d == -2) m_pat = 1;
                    m_prior = 0;
                end
            end
        end
    end

    // scoreboard compare, every cycle out of reset
    always @(negedge CLOCK_50) begin
        if (KEY[0] === 1'b1) begin
            check("digit", int'(DIGIT), m_digit);
            check("digit_valid", int'(DIGIT_VALID), int'(m_valid));
            check("pat_err", int'(PAT_ERR), int'(m_pat));
            check("seq_err", int'(SEQ_ERR), int'(m_seq));
            check("locked", int'(LOCKED), int'(m_locked));
            check("chg_cnt", int'(CHG_CNT), m_cnt);
            check("dv_pe_exclusive", int'(DIGIT_VALID & PAT_ERR), 0);
            if (DIGIT_VALID) dv_count++;
            if (PAT_ERR) pe_count++;
            if (!LOCKED) low_count++;
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic hold(input logic [0:6] p, input int n);
        HEX_IN = p;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        #2 KEY = 1'b0;
        HEX_IN = BLANK;
        repeat (2) @(negedge CLOCK_50);
        #2 KEY = 1'b1;
        @(negedge CLOCK_50);
    endtask

    int dv0, pe0, low0;

    initial begin
        KEY    = 1'b0;
        HEX_IN = BLANK;
        repeat (3) @(negedge CLOCK_50);
        check("rst_digit", int'(DIGIT), 0);
        check("rst_chg_cnt", int'(CHG_CNT), 0);
        check("rst_locked", int'(LOCKED), 0);
        check("rst_state", int'(dbg_state), 0);
        #2 KEY = 1'b1;
        @(negedge CLOCK_50);

        // first digit latency: pulse exactly at edge 6
        HEX_IN = seg_tab[1];
        for (int e = 1; e <= 6; e++) begin
            @(posedge CLOCK_50);
            #1;
            check($sformatf("latency_edge%0d", e), int'(DIGIT_VALID), (e == 6) ? 1 : 0);
        end
        check("first_digit", int'(DIGIT), 1);
        check("first_locked", int'(LOCKED), 1);
        check("first_cnt", int'(CHG_CNT), 1);
        check("first_seq", int'(SEQ_ERR), 0);
        @(negedge CLOCK_50);
        hold(seg_tab[1], 4);

        // count 0..7 then 0
        do_reset();
        dv0 = dv_count;
        for (int d = 0; d < 8; d++) hold(seg_tab[d], 10);
        hold(seg_tab[0], 10);
        check("seq_pulses", dv_count - dv0, 9);
        check("seq_cnt", int'(CHG_CNT), 9);
        check("seq_ok", int'(SEQ_ERR), 0);

        // broken sequence 2 -> 4, sticky
        do_reset();
        hold(seg_tab[2], 10);
        check("seq_before", int'(SEQ_ERR), 0);
        hold(seg_tab[4], 10);
        check("seq_broken", int'(SEQ_ERR), 1);
        hold(seg_tab[5], 10);
        check("seq_sticky", int'(SEQ_ERR), 1);

        // first digit >= MOD
        do_reset();
        hold(seg_tab[9], 10);
        check("ge_mod_digit", int'(DIGIT), 9);
        check("ge_mod_seq", int'(SEQ_ERR), 1);

        // short glitch while locked on 3
        do_reset();
        hold(seg_tab[3], 10);
        dv0 = dv_count; pe0 = pe_count; low0 = low_count;
        hold(ILLEGAL, 2);
        hold(seg_tab[3], 10);
        check("glitch_dv", dv_count - dv0, 0);
        check("glitch_pe", pe_count - pe0, 0);
        check("glitch_lock_dropped", int'(low_count > low0), 1);
        check("glitch_relocked", int'(LOCKED), 1);

        // stable illegal, then 5 treated as first digit
        do_reset();
        hold(seg_tab[3], 10);
        pe0 = pe_count;
        hold(ILLEGAL, 10);
        check("illegal_pe", pe_count - pe0, 1);
        check("illegal_digit_hold", int'(DIGIT), 3);
        hold(seg_tab[5], 10);
        check("after_illegal_digit", int'(DIGIT), 5);
        check("after_illegal_seq", int'(SEQ_ERR), 0);
        check("after_illegal_cnt", int'(CHG_CNT), 2);

        // fast toggling never qualifies
        do_reset();
        dv0 = dv_count; pe0 = pe_count;
        for (int i = 0; i < 8; i++) begin
            hold(seg_tab[1], 2);
            hold(ILLEGAL, 3);
        end
        hold(BLANK, 10);
        check("fast_dv", dv_count - dv0, 0);
        check("fast_pe", pe_count - pe0, 0);

        // reset mid-settle discards the candidate
        do_reset();
        hold(seg_tab[4], 10);
        hold(seg_tab[5], 4);
        #2 KEY = 1'b0;
        #1;
        check("async_digit", int'(DIGIT), 0);
        check("async_cnt", int'(CHG_CNT), 0);
        check("async_locked", int'(LOCKED), 0);
        check("async_dv", int'(DIGIT_VALID), 0);
        check("async_state", int'(dbg_state), 0);
        @(negedge CLOCK_50);
        #2 KEY = 1'b1;
        @(negedge CLOCK_50);
        repeat (10) @(negedge CLOCK_50);
        check("post_reset_digit", int'(DIGIT), 5);
        check("post_reset_cnt", int'(CHG_CNT), 1);

        // 256 accepted transitions wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) hold(seg_tab[i % 2], 6);
        check("wrap_cnt", int'(CHG_CNT), 0);
        check("wrap_digit", int'(DIGIT), 1);
        check("wrap_seq", int'(SEQ_ERR), 0);

        hold(BLANK, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
